// File: rtl/instr_sequencer.sv
// Purpose: loads 16-bit instructions byte-wise and issues them in order to a consumer.
// Latency: first instruction is offered one cycle after start; sustains one transfer per cycle.
// Backpressure: inst_out and pc hold while inst_valid=1 and inst_ready=0.
module instr_sequencer #(
    parameter int         DEPTH   = 8,
    parameter logic [2:0] HALT_OP = 3'b111
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       clear,
    output logic [15:0]                inst_out,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_pc, w_pc_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic            r_ovf, w_ovf_nxt;
    logic            r_phase, w_phase_nxt;
    logic [7:0]      r_lo, w_lo_nxt;
    logic            w_wr;
    logic [15:0]     r_mem [DEPTH];
    logic [15:0]     w_rd;
    logic            w_full;
    logic            w_last;
    logic            w_halt;

    assign w_rd   = r_mem[r_pc];
    assign w_full = (r_count == CW'(DEPTH));
    assign w_last = ({1'b0, r_pc} == (r_count - CW'(1)));
    assign w_halt = (w_rd[2:0] == HALT_OP);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_phase_nxt = r_phase;
        w_lo_nxt    = r_lo;
        w_wr        = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_phase_nxt = 1'b0;
        end else if (r_state == S_RUN) begin
            if (abort) begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
            end else if (inst_ready) begin
                // The final transfer leaves pc on the last issued slot.
                if (w_halt || w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_pc_nxt = r_pc + PW'(1);
                end
            end
        end else begin
            if (start) begin
                if (r_count != '0) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                end
            end else if (byte_valid) begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
                if (w_full) begin
                    w_ovf_nxt = 1'b1;
                end else if (!r_phase) begin
                    w_lo_nxt    = byte_in;
                    w_phase_nxt = 1'b1;
                end else begin
                    w_wr        = 1'b1;
                    w_count_nxt = r_count + CW'(1);
                    w_phase_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_phase <= 1'b0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_phase <= w_phase_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Program storage carries no reset; only written slots are ever offered.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_count[PW-1:0]] <= {byte_in, r_lo};
        end
    end

    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign inst_valid = busy;
    assign inst_out   = busy ? w_rd : 16'h0000;
    assign pc         = r_pc;
    assign count      = r_count;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with DEPTH=8 and HALT_OP=3'b111.
module tb_instr_sequencer;
    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        start;
    logic        abort;
    logic        clear;
    logic [15:0] inst_out;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  pc;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    instr_sequencer #(.DEPTH(8), .HALT_OP(3'b111)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .start(start), .abort(abort), .clear(clear), .inst_out(inst_out),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .pc(pc), .count(count),
        .busy(busy), .done(done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] w);
        byte_valid = 1'b1;
        byte_in    = w[7:0];
        tick();
        byte_in    = w[15:8];
        tick();
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; start = 1'b0;
        abort = 1'b0; clear = 1'b0; inst_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_inst", 32'(inst_out), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_flags", 32'({busy, done, overflow}), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("idle_after_rst", 32'({busy, done}), 0);

        // Basic two-word run with consumer always ready
        load_word(16'h1C43);
        load_word(16'h2563);
        chk("load2_count", 32'(count), 2);
        inst_ready = 1'b1;
        do_start();
        chk("r1_valid", 32'(inst_valid), 1);
        chk("r1_busy", 32'(busy), 1);
        chk("r1_inst0", 32'(inst_out), 32'h1C43);
        chk("r1_pc0", 32'(pc), 0);
        tick();
        chk("r1_inst1", 32'(inst_out), 32'h2563);
        chk("r1_pc1", 32'(pc), 1);
        tick();
        chk("r1_done", 32'(done), 1);
        chk("r1_valid_off", 32'(inst_valid), 0);
        chk("r1_inst_off", 32'(inst_out), 0);
        chk("r1_count", 32'(count), 2);
        chk("r1_pc_final", 32'(pc), 1);

        // Backpressure: four stalled cycles on slot 0, then streaming
        do_clear();
        chk("clr_count", 32'(count), 0);
        load_word(16'h1110);
        load_word(16'h2220);
        load_word(16'h3330);
        inst_ready = 1'b0;
        do_start();
        for (int i = 0; i < 4; i++) begin
            chk("stall_inst", 32'(inst_out), 32'h1110);
            chk("stall_pc", 32'(pc), 0);
            if (i < 3) tick();
        end
        inst_ready = 1'b1;
        tick();
        chk("bp_inst1", 32'(inst_out), 32'h2220);
        chk("bp_pc1", 32'(pc), 1);
        tick();
        chk("bp_inst2", 32'(inst_out), 32'h3330);
        chk("bp_pc2", 32'(pc), 2);
        tick();
        chk("bp_done", 32'(done), 1);
        chk("bp_pc_final", 32'(pc), 2);

        // HALT opcode at slot 1 ends the run after its transfer
        do_clear();
        load_word(16'h0003);
        load_word(16'h0007);
        load_word(16'h0013);
        do_start();
        chk("h_inst0", 32'(inst_out), 32'h0003);
        tick();
        chk("h_inst1", 32'(inst_out), 32'h0007);
        chk("h_valid1", 32'(inst_valid), 1);
        tick();
        chk("h_done", 32'(done), 1);
        chk("h_pc", 32'(pc), 1);
        repeat (3) tick();
        chk("h_pc_hold", 32'(pc), 1);

        // Restart from DONE; stalled run ignores bytes; abort beats start
        inst_ready = 1'b0;
        do_start();
        chk("rs_pc0", 32'(pc), 0);
        chk("rs_inst0", 32'(inst_out), 32'h0003);
        byte_valid = 1'b1; byte_in = 8'hAA;
        tick();
        byte_valid = 1'b0;
        chk("run_byte_ign", 32'(count), 3);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("ab_busy", 32'({busy, done}), 0);
        chk("ab_pc", 32'(pc), 0);
        do_start();
        chk("ab_restart", 32'(inst_out), 32'h0003);
        chk("ab_restart_pc", 32'(pc), 0);
        inst_ready = 1'b1;
        tick();
        chk("ab2_pc1", 32'(pc), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab2_idle", 32'(inst_valid), 0);
        chk("ab2_pc", 32'(pc), 0);

        // Fill all eight slots, then overflow
        do_clear();
        for (int i = 0; i < 8; i++) load_word(16'h0A00 + 16'(i * 16));
        chk("full_count", 32'(count), 8);
        chk("full_ovf0", 32'(overflow), 0);
        load_word(16'hFFFF);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        do_start();
        repeat (7) tick();
        chk("full_pc7", 32'(pc), 7);
        chk("full_inst7", 32'(inst_out), 32'h0A70);
        tick();
        chk("full_done", 32'(done), 1);
        chk("full_pc_final", 32'(pc), 7);
        do_clear();
        chk("clr2_count", 32'(count), 0);
        chk("clr2_ovf", 32'(overflow), 0);
        do_start();
        chk("empty_start", 32'(busy), 0);

        // Asynchronous reset in the middle of a five-word run
        for (int i = 0; i < 5; i++) load_word(16'h4000 + 16'(i * 8));
        do_start();
        tick();
        tick();
        chk("pre_rst_pc", 32'(pc), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid), 0);
        chk("arst_pc", 32'(pc), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_inst", 32'(inst_out), 0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'({busy, done, overflow}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
